// File: rtl/pipeline_exec_pkg.sv
// Shared encodings for the pipeline execution controller.
// Optional breakpoint support: PIPELINE_EXEC_BREAKPOINT_EN.
package pipeline_exec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/sat_cycle_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_cycle_counter #(
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [NB_CNT-1:0] o_count
);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      o_count <= '0;
    end else if (i_en && (o_count != {NB_CNT{1'b1}})) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Run/step/stop execution controller with HALT drain and cycle count.
// Define PIPELINE_EXEC_BREAKPOINT_EN to add PC breakpoint ports.
module pipeline_exec_ctrl
  import pipeline_exec_pkg::*;
#(
  parameter int NB_CNT       = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int NB_DRAIN     = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  input  logic [1:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_halt_fetched,
  input  logic              i_halt_wb,
  output logic              o_step,
  output logic              o_pc_hold,
  output logic              o_done,
  output logic              o_halted,
  output logic              o_busy,
  output logic [2:0]        o_state,
  output logic [NB_CNT-1:0] o_cycle_count
`ifdef PIPELINE_EXEC_BREAKPOINT_EN
  ,
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_bp_addr,
  input  logic              i_bp_valid,
  output logic              o_bp_hit
`endif
);

  state_t state, state_n;
  logic [NB_DRAIN-1:0] drain_cnt, drain_n;
  logic done, done_n;
  logic cmd_acc;
  logic bp_match;
  logic step_en;

  assign o_cmd_ready = (state == ST_IDLE) |
                       (state == ST_RUN)  |
                       (state == ST_HALTED);
  assign cmd_acc = i_cmd_valid & o_cmd_ready;

  assign step_en = (state == ST_RUN)  |
                   (state == ST_STEP) |
                   (state == ST_DRAIN);

`ifdef PIPELINE_EXEC_BREAKPOINT_EN
  logic bp_set;
  logic bp_hit;
  assign bp_match = i_bp_valid & (i_pc == i_bp_addr);
  assign o_bp_hit = bp_hit;
`else
  assign bp_match = 1'b0;
`endif

  always_comb begin
    state_n = state;
    drain_n = drain_cnt;
    done_n  = 1'b0;
`ifdef PIPELINE_EXEC_BREAKPOINT_EN
    bp_set  = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (cmd_acc && i_cmd == CMD_RUN) begin
          state_n = ST_RUN;
        end else if (cmd_acc && i_cmd == CMD_STEP) begin
          state_n = ST_STEP;
        end
      end
      ST_RUN: begin
        if (i_halt_wb) begin
          state_n = ST_HALTED;
          done_n  = 1'b1;
        end else if (bp_match) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
`ifdef PIPELINE_EXEC_BREAKPOINT_EN
          bp_set  = 1'b1;
`endif
        end else if (i_halt_fetched) begin
          state_n = ST_DRAIN;
          drain_n = NB_DRAIN'(DRAIN_CYCLES);
        end else if (cmd_acc && i_cmd == CMD_STOP) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      ST_STEP: begin
        done_n  = 1'b1;
        state_n = i_halt_wb ? ST_HALTED : ST_IDLE;
      end
      ST_DRAIN: begin
        drain_n = drain_cnt - 1'b1;
        // drain ends when the counter would reach zero
        if (i_halt_wb || drain_cnt <= NB_DRAIN'(1)) begin
          state_n = ST_HALTED;
          done_n  = 1'b1;
        end
      end
      ST_HALTED: begin
        state_n = ST_HALTED;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_n;
      done      <= done_n;
    end
  end

`ifdef PIPELINE_EXEC_BREAKPOINT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bp_hit <= 1'b0;
    end else if (bp_set) begin
      bp_hit <= 1'b1;
    end else if (cmd_acc && i_cmd != CMD_NOP) begin
      bp_hit <= 1'b0;
    end
  end
`endif

  assign o_step    = step_en;
  assign o_busy    = step_en;
  assign o_pc_hold = (state == ST_DRAIN);
  assign o_halted  = (state == ST_HALTED);
  assign o_done    = done;
  assign o_state   = state;

  sat_cycle_counter #(
    .NB_CNT (NB_CNT)
  ) u_cycle_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_reset),
    .i_en    (step_en),
    .o_count (o_cycle_count)
  );

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed + random bench for pipeline_exec_ctrl against a cycle model.
module tb_pipeline_exec_ctrl;
  import pipeline_exec_pkg::*;

  logic        i_clk;
  logic        i_reset;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic        i_halt_fetched;
  logic        i_halt_wb;

  logic        o_cmd_ready, o_step, o_pc_hold;
  logic        o_done, o_halted, o_busy;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_count;

  logic        r4, s4, h4, d4, hl4, b4;
  logic [2:0]  st4;
  logic [3:0]  cnt4;

  pipeline_exec_ctrl #(.NB_CNT(32)) u_dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_cmd_valid    (i_cmd_valid),
    .i_cmd          (i_cmd),
    .o_cmd_ready    (o_cmd_ready),
    .i_halt_fetched (i_halt_fetched),
    .i_halt_wb      (i_halt_wb),
    .o_step         (o_step),
    .o_pc_hold      (o_pc_hold),
    .o_done         (o_done),
    .o_halted       (o_halted),
    .o_busy         (o_busy),
    .o_state        (o_state),
    .o_cycle_count  (o_cycle_count)
  );

  pipeline_exec_ctrl #(.NB_CNT(4)) u_dut4 (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_cmd_valid    (i_cmd_valid),
    .i_cmd          (i_cmd),
    .o_cmd_ready    (r4),
    .i_halt_fetched (i_halt_fetched),
    .i_halt_wb      (i_halt_wb),
    .o_step         (s4),
    .o_pc_hold      (h4),
    .o_done         (d4),
    .o_halted       (hl4),
    .o_busy         (b4),
    .o_state        (st4),
    .o_cycle_count  (cnt4)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;
  int done_seen = 0;
  int hold_seen = 0;
  int step_seen = 0;

  // reference model: mode 0 idle, 1 run, 2 step, 3 drain, 4 halted
  int    m_mode;
  int    m_left;
  bit    m_done;
  longint m_count;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [5:0] exp_flags();
    bit stp, rdy;
    stp = (m_mode >= 1 && m_mode <= 3);
    rdy = (m_mode == 0 || m_mode == 1 || m_mode == 4);
    return {stp, m_mode == 3, m_done, m_mode == 4, stp, rdy};
  endfunction

  task automatic model_step(input bit rst, v, input logic [1:0] c,
                            input bit hf, hw);
    bit acc;
    int nxt;
    bit dn;
    acc = v && (m_mode == 0 || m_mode == 1 || m_mode == 4);
    nxt = m_mode;
    dn  = 0;
    if (m_mode >= 1 && m_mode <= 3) m_count++;
    case (m_mode)
      0: if (acc && c == CMD_RUN) nxt = 1;
         else if (acc && c == CMD_STEP) nxt = 2;
      1: if (hw) begin nxt = 4; dn = 1; end
         else if (hf) begin nxt = 3; m_left = 4; end
         else if (acc && c == CMD_STOP) begin nxt = 0; dn = 1; end
      2: begin nxt = hw ? 4 : 0; dn = 1; end
      3: begin
           m_left--;
           if (hw || m_left == 0) begin nxt = 4; dn = 1; end
         end
      default: nxt = m_mode;
    endcase
    m_mode = nxt;
    m_done = dn;
    if (rst) begin
      m_mode = 0; m_done = 0; m_count = 0; m_left = 0;
    end
  endtask

  task automatic cyc(input bit rst, v, input logic [1:0] c,
                     input bit hf, hw);
    logic [31:0] e32;
    logic [3:0]  e4;
    i_reset = rst; i_cmd_valid = v; i_cmd = c;
    i_halt_fetched = hf; i_halt_wb = hw;
    e32 = m_count[31:0];
    e4  = (m_count > 15) ? 4'hF : m_count[3:0];
    chk("state", {29'd0, o_state}, m_mode);
    chk("flags", {26'd0, o_step, o_pc_hold, o_done, o_halted,
                  o_busy, o_cmd_ready}, {26'd0, exp_flags()});
    chk("count", o_cycle_count, e32);
    chk("state4", {29'd0, st4}, m_mode);
    chk("flags4", {26'd0, s4, h4, d4, hl4, b4, r4},
        {26'd0, exp_flags()});
    chk("count4", {28'd0, cnt4}, {28'd0, e4});
    if (o_done) done_seen++;
    if (o_pc_hold) hold_seen++;
    if (o_step) step_seen++;
    model_step(rst, v, c, hf, hw);
    @(posedge i_clk); #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, CMD_NOP, 0, 0);
  endtask

  initial begin
    i_reset = 1; i_cmd_valid = 0; i_cmd = CMD_NOP;
    i_halt_fetched = 0; i_halt_wb = 0;
    @(posedge i_clk); #1;
    m_mode = 0; m_done = 0; m_count = 0; m_left = 0;
    cyc(1, 0, CMD_NOP, 0, 0);

    // three single steps
    done_seen = 0; step_seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, CMD_STEP, 0, 0);
      nop(1);
    end
    nop(1);
    chk("step3_count", o_cycle_count, 32'd3);
    chk("step3_done", done_seen, 3);
    chk("step3_steps", step_seen, 3);

    // run 10 cycles then stop
    done_seen = 0;
    cyc(0, 1, CMD_RUN, 0, 0);
    nop(9);
    cyc(0, 1, CMD_STOP, 0, 0);
    nop(1);
    chk("stop_count", o_cycle_count, 32'd13);
    chk("stop_done", done_seen, 1);
    chk("stop_busy", {31'd0, o_busy}, 32'd0);

    // halt fetched then reaches writeback
    done_seen = 0; hold_seen = 0;
    cyc(0, 1, CMD_RUN, 0, 0);
    nop(4);
    cyc(0, 0, CMD_NOP, 1, 0);
    nop(3);
    cyc(0, 0, CMD_NOP, 0, 1);
    cyc(0, 1, CMD_RUN, 0, 0);
    nop(2);
    chk("halt_hold", hold_seen, 4);
    chk("halt_done", done_seen, 1);
    chk("halt_state", {29'd0, o_state}, 32'd4);

    // drain timeout
    cyc(1, 0, CMD_NOP, 0, 0);
    hold_seen = 0;
    cyc(0, 1, CMD_RUN, 0, 0);
    cyc(0, 0, CMD_NOP, 1, 0);
    nop(6);
    chk("timeout_hold", hold_seen, 4);
    chk("timeout_halted", {31'd0, o_halted}, 32'd1);

    // stop together with halt writeback
    cyc(1, 0, CMD_NOP, 0, 0);
    done_seen = 0;
    cyc(0, 1, CMD_RUN, 0, 0);
    nop(2);
    cyc(0, 1, CMD_STOP, 0, 1);
    nop(3);
    chk("stophw_done", done_seen, 1);
    chk("stophw_halted", {31'd0, o_halted}, 32'd1);

    // reset in the middle of a drain
    cyc(1, 0, CMD_NOP, 0, 0);
    cyc(0, 1, CMD_RUN, 0, 0);
    cyc(0, 0, CMD_NOP, 1, 0);
    nop(2);
    cyc(1, 0, CMD_NOP, 0, 0);
    chk("rst_flags", {26'd0, o_step, o_pc_hold, o_done, o_halted,
                      o_busy, o_cmd_ready}, 32'd1);
    chk("rst_state", {29'd0, o_state}, 32'd0);
    chk("rst_count", o_cycle_count, 32'd0);

    // narrow counter saturates
    cyc(0, 1, CMD_RUN, 0, 0);
    nop(20);
    chk("sat_count4", {28'd0, cnt4}, 32'd15);
    chk("sat_count32", o_cycle_count, 32'd20);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(39) == 0,
          $urandom_range(1) == 1,
          2'($urandom_range(3)),
          $urandom_range(9) == 0,
          $urandom_range(14) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_exec_ctrl.md
Name: pipeline_exec_ctrl

Overview:
Execution controller for the MIPS pipeline. It accepts run, step and stop commands from the debug unit over a valid/ready handshake and generates the global step enable (o_step) that feeds the PC step input and the pipeline registers. It also generates the PC hold (o_pc_hold) that feeds the PC stall input. On HALT it freezes fetch, drains the pipeline, counts executed cycles and reports completion to the debug unit.

Parameters:
NB_CNT, 32, width of executed-cycle counter
DRAIN_CYCLES, 4, max cycles from HALT fetched to HALT reaching writeback (drain timeout)
NB_DRAIN, 3, width of drain down-counter; must hold DRAIN_CYCLES

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command valid from debug unit
i_cmd  in  2  command: 00 NOP, 01 RUN, 10 STEP, 11 STOP
o_cmd_ready  out  1  controller accepts command this cycle
i_halt_fetched  in  1  HALT opcode detected in fetch stage
i_halt_wb  in  1  HALT instruction reached writeback
o_step  out  1  pipeline/PC advance enable
o_pc_hold  out  1  freeze PC (drives PC stall input)
o_done  out  1  one-cycle pulse: step finished, run paused, or halted
o_halted  out  1  level: program finished
o_busy  out  1  RUN, STEP or DRAIN active
o_state  out  3  current state encoding (debug readout)
o_cycle_count  out  NB_CNT  cycles with o_step=1, saturating

Behaviour:
- Reset, i_clk and i_reset as decided above; reset has priority over all events. Reset applies mid-operation too.
- Reset values: state IDLE, o_step 0, o_pc_hold 0, o_done 0, o_halted 0, o_busy 0, o_cycle_count 0, o_cmd_ready 1.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- A command is accepted when i_cmd_valid & o_cmd_ready. NOP is accepted and ignored.
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- IDLE:
  - o_cmd_ready=1.
  - RUN -> RUN.
  - STEP -> STEP.
  - STOP -> stays IDLE.
- RUN:
  - o_step=1 every cycle; o_cmd_ready=1.
  - Events in priority order:
    - i_halt_wb -> HALTED.
    - i_halt_fetched -> DRAIN; load drain counter with DRAIN_CYCLES.
    - STOP accepted -> IDLE with o_done pulse.
    - RUN/STEP accepted -> ignored.
- STEP:
  - Lasts exactly one cycle with o_step=1; o_cmd_ready=0.
  - Next state IDLE with o_done=1 for one cycle.
  - If i_halt_wb is asserted during the step cycle, next state is HALTED instead.
  - i_halt_fetched is ignored; the user keeps stepping until HALT reaches writeback.
- Latency: command accepted in cycle N -> o_step first high in N+1 -> (STEP) o_done high in N+2.
- DRAIN:
  - o_step=1, o_pc_hold=1, o_cmd_ready=0.
  - Drain counter decrements each cycle.
  - Exits to HALTED on i_halt_wb or when the counter reaches 0 (timeout), whichever comes first.
- HALTED:
  - o_step=0, o_pc_hold=0, o_halted=1, o_busy=0.
  - o_done pulses on the entry cycle only.
  - o_cmd_ready=1; all commands are accepted and ignored. Only reset exits.
- Simultaneous events:
  - i_halt_fetched & i_halt_wb together -> HALTED.
  - STOP & i_halt_wb together -> HALTED, single o_done pulse.
- Counter: +1 in each cycle where o_step=1; saturates at all-ones (no wrap); cleared only by reset.
- o_busy=1 in RUN, STEP, DRAIN.

Optional Feature:
PIPELINE_EXEC_BREAKPOINT_EN
- Defined:
  - Adds ports i_pc [31:0], i_bp_addr [31:0], i_bp_valid [1], o_bp_hit [1].
  - In RUN, i_bp_valid & (i_pc == i_bp_addr) -> IDLE with o_done pulse and o_bp_hit set.
  - Breakpoint priority: below i_halt_wb, above i_halt_fetched.
  - o_bp_hit is sticky; it clears on the next accepted non-NOP command or on reset.
- Undefined: ports absent; RUN is unaffected by PC value.

Decomposition:
- Shared package pipeline_exec_pkg:
  - state encodings (ST_IDLE..ST_HALTED)
  - command codes (CMD_NOP, CMD_RUN, CMD_STEP, CMD_STOP)
  - default DRAIN_CYCLES
- One sub-module: sat_cycle_counter (parameterised NB_CNT saturating counter with enable and synchronous clear).

Test Plan:
- Reset, then STEP x3 -> o_step high exactly 3 isolated cycles, o_done 3 pulses each 2 cycles after acceptance, o_cycle_count=3.
- RUN, STOP accepted after 10 cycles of o_step -> IDLE, o_cycle_count=10, one o_done pulse, o_busy=0.
- RUN, i_halt_fetched at cycle 5, i_halt_wb 4 cycles later -> o_pc_hold high 4 cycles, then HALTED, o_halted=1, single o_done; a subsequent RUN is ignored.
- RUN, i_halt_fetched, i_halt_wb never asserted -> HALTED after exactly DRAIN_CYCLES=4 drain cycles.
- STOP and i_halt_wb in the same RUN cycle -> HALTED, exactly one o_done; i_reset asserted in DRAIN -> all outputs at reset values next cycle.
- NB_CNT=4, RUN 20 cycles -> o_cycle_count holds 15, no wrap.
